// File: rtl/rx_pkg.sv
// ============================================================================
// Package    : rx_pkg
// Description: Shared types and constants for the UART receive framing stage.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package rx_pkg;

    localparam int SR_BITS  = 9;
    localparam int MAX_DATA = 8;
    localparam int MIN_DATA = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        CHECK = 3'd2,
        LOAD  = 3'd3,
        FERR  = 3'd4
    } rx_state_t;

    // Right-shift that right-justifies a short word; illegal sizes extract as 8 bits.
    function automatic logic [3:0] extract_shift(input logic [3:0] data_size);
        if (data_size >= 4'(MIN_DATA) && data_size <= 4'(MAX_DATA))
            return 4'(MAX_DATA) - data_size;
        return 4'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/start_bit_det.sv
// ============================================================================
// Module     : start_bit_det
// Description: serial_in synchroniser plus falling-edge (start) detector.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module start_bit_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_serial,
    output logic o_sync,
    output logic o_start
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_serial};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync  = r_sync[SYNC_STAGES-1];
    assign o_start = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rx_frame_ctrl.sv
// ============================================================================
// Module     : rx_frame_ctrl
// Description: UART receive framing: start detect, bit capture, frame check, flags.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rx_frame_ctrl
    import rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       serial_in,
    input  logic [3:0] data_size,
    input  logic       shift_enable,
    input  logic       packet_done,
    input  logic       data_read,
    output logic       enable_timer,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       overrun_error,
    output logic       framing_error
);

    logic               w_s;
    logic               w_start;
    logic [3:0]         w_shamt;
    rx_state_t          r_state;
    logic [SR_BITS-1:0] r_sr;
    logic               r_enable_timer;
    logic [7:0]         r_rx_data;
    logic               r_data_ready;
    logic               r_overrun_error;
    logic               r_framing_error;

    start_bit_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_start_bit_det (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_serial(serial_in),
        .o_sync  (w_s),
        .o_start (w_start)
    );

    assign w_shamt = extract_shift(data_size);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= IDLE;
            r_sr            <= '1;
            r_enable_timer  <= 1'b0;
            r_rx_data       <= 8'h00;
            r_data_ready    <= 1'b0;
            r_overrun_error <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            // A read clears the flags everywhere; LOAD below overrides it.
            if (data_read) begin
                r_data_ready    <= 1'b0;
                r_overrun_error <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state         <= RECV;
                        r_enable_timer  <= 1'b1;
                        r_framing_error <= 1'b0;
                        r_sr            <= '1;
                    end
                end
                RECV: begin
                    if (shift_enable)
                        r_sr <= {w_s, r_sr[SR_BITS-1:1]};
                    if (packet_done) begin
                        r_state        <= CHECK;
                        r_enable_timer <= 1'b0;
                    end
                end
                CHECK: begin
                    r_state <= r_sr[SR_BITS-1] ? LOAD : FERR;
                end
                LOAD: begin
                    r_rx_data    <= r_sr[MAX_DATA-1:0] >> w_shamt;
                    r_data_ready <= 1'b1;
                    if (r_data_ready && !data_read)
                        r_overrun_error <= 1'b1;
                    r_state <= IDLE;
                end
                FERR: begin
                    r_framing_error <= 1'b1;
                    r_state         <= IDLE;
                end
                default: begin
                    r_state        <= IDLE;
                    r_enable_timer <= 1'b0;
                end
            endcase
        end
    end

    assign enable_timer  = r_enable_timer;
    assign rx_data       = r_rx_data;
    assign data_ready    = r_data_ready;
    assign overrun_error = r_overrun_error;
    assign framing_error = r_framing_error;

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
// ============================================================================
// Module     : tb_rx_frame_ctrl
// Description: Self-checking bench for rx_frame_ctrl with a frame-level model.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_rx_frame_ctrl;

    logic       clk          = 1'b0;
    logic       n_rst        = 1'b0;
    logic       serial_in    = 1'b1;
    logic [3:0] data_size    = 4'd8;
    logic       shift_enable = 1'b0;
    logic       packet_done  = 1'b0;
    logic       data_read    = 1'b0;
    logic       enable_timer;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;

    int n_cmp = 0;
    int n_err = 0;

    // Frame-level reference state
    logic [7:0] m_data  = 8'h00;
    logic       m_ready = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;

    rx_frame_ctrl #(
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .data_size    (data_size),
        .shift_enable (shift_enable),
        .packet_done  (packet_done),
        .data_read    (data_read),
        .enable_timer (enable_timer),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .overrun_error(overrun_error),
        .framing_error(framing_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'(m_data));
        chk({tag, "_ready"},   32'(data_ready), 32'(m_ready));
        chk({tag, "_overrun"}, 32'(overrun_error), 32'(m_ovr));
        chk({tag, "_framing"}, 32'(framing_error), 32'(m_ferr));
    endtask

    task automatic rd_pulse();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        chk("read_ready", 32'(data_ready), 32'(m_ready));
        chk("read_overrun", 32'(overrun_error), 32'(m_ovr));
    endtask

    task automatic idle_pd_pulse();
        packet_done = 1'b1;
        tick();
        packet_done = 1'b0;
        tick();
        chk("idle_pd_timer", 32'(enable_timer), 32'd0);
        chk_outputs("idle_pd");
    endtask

    // Drive one frame on the wire and strobe the timer inputs directly.
    task automatic send_frame(input logic [3:0] ds, input logic [7:0] data, input logic stop,
                              input bit pd_late, input bit rd_load, input bit glitch,
                              input int abort_at);
        int         nb;
        int         lat;
        int         hits;
        logic [7:0] mask;
        nb   = (ds >= 4'd5 && ds <= 4'd8) ? int'(ds) : 8;
        mask = 8'((1 << nb) - 1);
        data_size = ds;

        serial_in = 1'b0;
        lat = 0;
        while (enable_timer !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk("start_latency", 32'(lat), 32'd3);
        m_ferr = 1'b0;
        chk("start_clears_ferr", 32'(framing_error), 32'(m_ferr));
        ticks(3);

        for (int i = 0; i < nb; i++) begin
            if (i == abort_at) begin
                n_rst = 1'b0;
                #2;
                m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
                chk("abort_timer", 32'(enable_timer), 32'd0);
                chk_outputs("abort");
                tick();
                serial_in = 1'b1;
                n_rst = 1'b1;
                hits = 0;
                for (int j = 0; j < 5; j++) begin
                    tick();
                    if (enable_timer) hits++;
                end
                chk("abort_stays_idle", 32'(hits), 32'd0);
                return;
            end
            serial_in = data[i];
            ticks(3);
            shift_enable = 1'b1;
            tick();
            shift_enable = 1'b0;
            ticks(2);
        end

        serial_in = stop;
        ticks(3);
        if (glitch) begin
            serial_in = 1'b0;
            tick();
        end
        shift_enable = 1'b1;
        packet_done  = !pd_late;
        tick();
        shift_enable = 1'b0;
        if (pd_late) begin
            packet_done = 1'b1;
            tick();
        end
        packet_done = 1'b0;
        chk("timer_drops_in_check", 32'(enable_timer), 32'd0);
        tick();
        chk("ready_not_early", 32'(data_ready), 32'(m_ready));
        data_read = rd_load;
        tick();
        data_read = 1'b0;

        if (stop) begin
            if (rd_load)      m_ovr = 1'b0;
            else if (m_ready) m_ovr = 1'b1;
            m_data  = data & mask;
            m_ready = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        chk_outputs("frame");

        if (glitch) begin
            hits = 0;
            for (int j = 0; j < 8; j++) begin
                tick();
                if (enable_timer) hits++;
            end
            chk("late_edge_ignored", 32'(hits), 32'd0);
        end
        serial_in = 1'b1;
        ticks(4);
    endtask

    initial begin
        int hits;
        logic [3:0] ds;
        logic       stop;
        bit         pd_late;
        bit         rd_load;
        bit         glitch;
        int         abort_at;

        // Reset with a busy line
        for (int i = 0; i < 6; i++) begin
            serial_in = 1'($urandom);
            tick();
        end
        chk("reset_timer", 32'(enable_timer), 32'd0);
        chk_outputs("reset");
        serial_in = 1'b1;
        n_rst = 1'b1;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (enable_timer) hits++;
        end
        chk("post_reset_idle", 32'(hits), 32'd0);

        send_frame(4'd8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        rd_pulse();
        send_frame(4'd5, 8'h0D, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        send_frame(4'd8, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        rd_pulse();
        send_frame(4'd8, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        send_frame(4'd8, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        rd_pulse();
        send_frame(4'd8, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        send_frame(4'd8, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        send_frame(4'd7, 8'h4B, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        send_frame(4'd6, 8'h2E, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        idle_pd_pulse();
        send_frame(4'd8, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        send_frame(4'd12, 8'h96, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        for (int n = 0; n < 30; n++) begin
            ds       = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(5, 8));
            stop     = ($urandom_range(0, 4) != 0);
            pd_late  = 1'($urandom);
            rd_load  = stop && ($urandom_range(0, 3) == 0);
            glitch   = stop && !pd_late && ($urandom_range(0, 4) == 0);
            abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            send_frame(ds, 8'($urandom), stop, pd_late, rd_load, glitch, abort_at);
            case ($urandom_range(0, 3))
                0:       rd_pulse();
                1:       idle_pd_pulse();
                default: ticks(int'($urandom_range(0, 3)));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
